// File: rtl/startup_menu.sv
// rtl/startup_menu.sv - start-screen menu: debounced selection, blinking cursor overlay, game start handoff.
// Optional STARTUP_MENU_WRAP_EN makes the selection wrap instead of saturating.
module startup_menu #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_FRAMES    = 15,
  parameter int CONFIRM_FRAMES  = 60,
  parameter int CURSOR_X        = 200,
  parameter int CURSOR_SIZE     = 24,
  parameter int SP_Y            = 258,
  parameter int MP_Y            = 301
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic       in_text,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       game_over,
  output logic       menu_pixel,
  output logic       mode,
  output logic       start_game,
  output logic       menu_active
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam int CW = $clog2(CONFIRM_FRAMES) + 1;

  typedef enum logic [1:0] {MENU, CONFIRM, PLAYING} state_t;

  // Button index: 0 = up, 1 = down, 2 = start
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2, level, level_d;
  logic [DW-1:0] dcnt [3];
  logic [2:0]    press;

  assign raw   = {btn_start, btn_down, btn_up};
  assign press = level & ~level_d;

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i] <= sync2[i];
          dcnt[i]  <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state, state_n;
  logic          sel, sel_n;
  logic          blink_vis, blink_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [CW-1:0] ccnt, ccnt_n;
  logic          start_n, mode_n;
  logic          up_ev, down_ev;

  assign up_ev   = press[0] & ~press[1];
  assign down_ev = press[1] & ~press[0];

  always_comb begin
    state_n = state;
    sel_n   = sel;
    blink_n = blink_vis;
    bcnt_n  = bcnt;
    ccnt_n  = ccnt;
    start_n = 1'b0;
    mode_n  = mode;
    case (state)
      MENU: begin
        if (frame_tick) begin
          if (bcnt >= BW'(BLINK_FRAMES - 1)) begin
            blink_n = ~blink_vis;
            bcnt_n  = '0;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
        if (press[2]) begin
          state_n = CONFIRM;
          ccnt_n  = '0;
        end else if (up_ev) begin
`ifdef STARTUP_MENU_WRAP_EN
          sel_n = ~sel;
`else
          sel_n = 1'b0;
`endif
        end else if (down_ev) begin
`ifdef STARTUP_MENU_WRAP_EN
          sel_n = ~sel;
`else
          sel_n = 1'b1;
`endif
        end
      end
      CONFIRM: begin
        if (frame_tick) begin
          blink_n = ~blink_vis;
          if (ccnt != CW'(CONFIRM_FRAMES)) ccnt_n = ccnt + 1'b1;
          if (ccnt_n == CW'(CONFIRM_FRAMES)) begin
            state_n = PLAYING;
            start_n = 1'b1;
            mode_n  = sel;
          end
        end
      end
      PLAYING: begin
        if (game_over) begin
          state_n = MENU;
          bcnt_n  = '0;
          blink_n = 1'b1;
        end
      end
      default: state_n = MENU;
    endcase
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state       <= MENU;
      sel         <= 1'b0;
      blink_vis   <= 1'b1;
      bcnt        <= '0;
      ccnt        <= '0;
      start_game  <= 1'b0;
      mode        <= 1'b0;
      menu_active <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      blink_vis   <= blink_n;
      bcnt        <= bcnt_n;
      ccnt        <= ccnt_n;
      start_game  <= start_n;
      mode        <= mode_n;
      menu_active <= (state_n != PLAYING);
    end
  end

  // Cursor hit and video_on are registered once to line up with in_text
  logic [10:0] px, py, ytop;
  logic        hit, hit_r, von_r;

  assign px   = {1'b0, pixel_x};
  assign py   = {1'b0, pixel_y};
  assign ytop = sel ? 11'(MP_Y) : 11'(SP_Y);
  assign hit  = (px >= 11'(CURSOR_X)) && (px < 11'(CURSOR_X + CURSOR_SIZE)) &&
                (py >= ytop) && (py < ytop + 11'(CURSOR_SIZE));

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      hit_r      <= 1'b0;
      von_r      <= 1'b0;
      menu_pixel <= 1'b0;
    end else begin
      hit_r      <= hit & blink_vis;
      von_r      <= video_on;
      menu_pixel <= (in_text | hit_r) & von_r & menu_active;
    end
  end

endmodule

// File: tb/tb_startup_menu.sv
// tb/tb_startup_menu.sv - directed vector bench for startup_menu with short debounce/blink/confirm settings.
module tb_startup_menu;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, frame_tick, in_text;
  logic       btn_up, btn_down, btn_start, game_over;
  logic       menu_pixel, mode, start_game, menu_active;

  int tests = 0;
  int fails = 0;

  always #5 clk_0 = ~clk_0;

  startup_menu #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_FRAMES(2),
    .CONFIRM_FRAMES(3)
  ) dut (
    .clk_0(clk_0), .rst(rst),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_tick(frame_tick), .in_text(in_text),
    .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
    .game_over(game_over),
    .menu_pixel(menu_pixel), .mode(mode), .start_game(start_game),
    .menu_active(menu_active)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       txt;
    logic       exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_0);
  endtask

  task automatic set_px(input logic [9:0] x, input logic [9:0] y, input logic von, input logic txt);
    pixel_x  = x;
    pixel_y  = y;
    video_on = von;
    in_text  = txt;
  endtask

  task automatic check_px(input string name, input logic [9:0] x, input logic [9:0] y, input logic exp);
    set_px(x, y, 1'b1, 1'b0);
    step(3);
    chk(name, menu_pixel, exp);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic press(input logic u, input logic d, input logic s, input int n);
    btn_up = u; btn_down = d; btn_start = s;
    step(n);
    btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
    step(12);
  endtask

  initial begin
    logic seen;
    vecs[0] = '{10'd100, 10'd100, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{10'd100, 10'd100, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{10'd100, 10'd100, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{10'd200, 10'd258, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{10'd223, 10'd281, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{10'd224, 10'd270, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{10'd199, 10'd270, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{10'd210, 10'd257, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{10'd210, 10'd282, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{10'd210, 10'd301, 1'b1, 1'b0, 1'b0};

    rst = 1'b0;
    set_px(10'd0, 10'd0, 1'b0, 1'b0);
    frame_tick = 1'b0; game_over = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
    step(3);
    chk("reset_menu_pixel", menu_pixel, 1'b0);
    chk("reset_mode", mode, 1'b0);
    chk("reset_start_game", start_game, 1'b0);
    chk("reset_menu_active", menu_active, 1'b0);
    rst = 1'b1;
    step(1);
    chk("menu_active_after_reset", menu_active, 1'b1);

    for (int i = 0; i < 10; i++) begin
      set_px(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].txt);
      step(3);
      chk($sformatf("vec%0d", i), menu_pixel, vecs[i].exp);
    end

    // Latency: pixel coords take 2 cycles, in_text takes 1
    set_px(10'd0, 10'd0, 1'b1, 1'b0);
    step(3);
    set_px(10'd210, 10'd270, 1'b1, 1'b0);
    step(1);
    chk("px_lat_1", menu_pixel, 1'b0);
    step(1);
    chk("px_lat_2", menu_pixel, 1'b1);
    set_px(10'd0, 10'd0, 1'b1, 1'b0);
    step(3);
    in_text = 1'b1;
    step(1);
    chk("text_lat_1", menu_pixel, 1'b1);

    press(1'b0, 1'b1, 1'b0, 2);
    check_px("glitch_sel0_row", 10'd210, 10'd270, 1'b1);
    check_px("glitch_sel1_row", 10'd210, 10'd310, 1'b0);

    press(1'b0, 1'b1, 1'b0, 10);
    check_px("down_sel1_row", 10'd210, 10'd310, 1'b1);
    check_px("down_sel0_row", 10'd210, 10'd270, 1'b0);
    check_px("down_sel1_bottom", 10'd210, 10'd324, 1'b1);
    press(1'b0, 1'b1, 1'b0, 10);
    check_px("down_sat", 10'd210, 10'd310, 1'b1);

    tick(); check_px("blink_f1", 10'd210, 10'd310, 1'b1);
    tick(); check_px("blink_f2", 10'd210, 10'd310, 1'b0);
    tick(); check_px("blink_f3", 10'd210, 10'd310, 1'b0);
    tick(); check_px("blink_f4", 10'd210, 10'd310, 1'b1);

    press(1'b0, 1'b0, 1'b1, 10);
    chk("confirm_active", menu_active, 1'b1);
    tick(); chk("confirm_t1", start_game, 1'b0);
    tick(); chk("confirm_t2", start_game, 1'b0);
    tick(); chk("confirm_t3_start", start_game, 1'b1);
    chk("confirm_mode", mode, 1'b1);
    chk("playing_inactive", menu_active, 1'b0);
    step(1);
    chk("start_one_cycle", start_game, 1'b0);
    set_px(10'd100, 10'd100, 1'b1, 1'b1);
    step(3);
    chk("playing_pixel_off", menu_pixel, 1'b0);
    press(1'b0, 1'b0, 1'b1, 10);
    chk("playing_ignores_start", menu_active, 1'b0);
    chk("playing_mode_hold", mode, 1'b1);

    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    chk("gameover_active", menu_active, 1'b1);
    check_px("gameover_sel_kept", 10'd210, 10'd310, 1'b1);

    press(1'b1, 1'b0, 1'b1, 10);
    chk("upstart_confirm", menu_active, 1'b1);
    check_px("upstart_sel1", 10'd210, 10'd310, 1'b1);
    check_px("upstart_not_sel0", 10'd210, 10'd270, 1'b0);
    tick();
    check_px("confirm_fast_blink", 10'd210, 10'd310, 1'b0);

    rst = 1'b0;
    #1;
    chk("abort_start", start_game, 1'b0);
    chk("abort_active", menu_active, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("abort_menu", menu_active, 1'b1);
    check_px("abort_sel0", 10'd210, 10'd270, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      seen |= start_game;
      step(1);
      seen |= start_game;
    end
    chk("abort_no_start", seen, 1'b0);

    press(1'b1, 1'b0, 1'b0, 10);
`ifdef STARTUP_MENU_WRAP_EN
    check_px("up_at0_row1", 10'd210, 10'd310, 1'b1);
    check_px("up_at0_row0", 10'd210, 10'd270, 1'b0);
`else
    check_px("up_at0_row1", 10'd210, 10'd310, 1'b0);
    check_px("up_at0_row0", 10'd210, 10'd270, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
